// File: rtl/pkt_pkg.sv
// Shared packet definitions for the 3-byte {header, addr, data, footer} frame.
// Used by both the transmitter and the matching receiver.
package pkt_pkg;

    localparam logic [2:0] PKT_HEADER = 3'b101;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;
    localparam int FOOTER_W  = 3;
    localparam int PKT_W     = 24;
    localparam int PKT_BYTES = 3;

    typedef enum logic [1:0] {
        PKT_IDLE,
        PKT_LOAD,
        PKT_WAIT,
        PKT_DONE
    } pkt_state_t;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    function automatic logic [PKT_W-1:0] pkt_pack(
        input logic [ADDR_W-1:0]   addr,
        input logic [DATA_W-1:0]   data,
        input logic [FOOTER_W-1:0] footer
    );
        return {PKT_HEADER, addr, data, footer};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser: start bit, 8 data bits LSB first, one stop bit.
// done pulses on the last cycle of the stop bit so the next byte can follow immediately.
module uart_tx_byte
    import pkt_pkg::*;
#(
    parameter int FREQ = 100_000_000,
    parameter int BAUD = 625_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       txd,
    output logic       done,
    output logic       busy
);

    localparam int CLKS_PER_BIT = FREQ / BAUD;
    localparam int CNT_BITS = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CLKS_PER_BIT - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    uart_state_t         r_state;
    uart_state_t         w_state_nxt;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_idx_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                r_txd;
    logic                w_txd_nxt;
    logic                w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_txd_nxt     = r_txd;
        case (r_state)
            UART_IDLE: begin
                w_txd_nxt = 1'b1;
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt   = UART_START;
                    w_txd_nxt     = 1'b0;
                    w_shift_nxt   = din;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            UART_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = UART_DATA;
                    w_txd_nxt   = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            UART_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = UART_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        // Next bit is read from the unshifted copy so txd lands on the boundary.
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_txd_nxt     = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            UART_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = UART_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= UART_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    assign txd  = r_txd;
    assign done = (r_state == UART_STOP) && w_bit_end;
    assign busy = (r_state != UART_IDLE);

endmodule

// File: rtl/pkt_uart_tx.sv
// Packet transmitter: accepts {addr, data, footer}, frames it behind header 3'b101
// and sends the three bytes over 8N1 UART with a one-cycle idle gap between bytes.
module pkt_uart_tx
    import pkt_pkg::*;
#(
    parameter int FREQ  = 100_000_000,
    parameter int BAUD  = 625_000,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    input  logic [ADDR_W-1:0]   pkt_addr,
    input  logic [DATA_W-1:0]   pkt_data,
    input  logic [FOOTER_W-1:0] pkt_footer,
    output logic                txd,
    output logic                tx_en,
    output logic [7:0]          tx_byte,
    output logic                busy,
    output logic [CNT_W-1:0]    count_packets
);

    localparam logic [1:0] LAST_IDX = 2'(PKT_BYTES - 1);

    // valid/ready: a packet is taken on any rising edge where pkt_valid && pkt_ready;
    // pkt_ready is a pure function of state so the sender may hold valid as long as it likes.
    pkt_state_t       r_state;
    pkt_state_t       w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [PKT_W-1:0] r_word;
    logic [CNT_W-1:0] r_count_packets;
    logic             w_accept;
    logic             w_start;
    logic [7:0]       w_byte;
    logic             w_ser_txd;
    logic             w_ser_done;
    logic             w_ser_busy;

    assign w_accept = pkt_valid && (r_state == PKT_IDLE);

    always_comb begin
        case (r_idx)
            2'd0:    w_byte = r_word[23:16];
            2'd1:    w_byte = r_word[15:8];
            default: w_byte = r_word[7:0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_start     = 1'b0;
        case (r_state)
            PKT_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = PKT_LOAD;
                    w_idx_nxt   = 2'd0;
                end
            end
            PKT_LOAD: begin
                w_start     = 1'b1;
                w_state_nxt = PKT_WAIT;
            end
            PKT_WAIT: begin
                if (w_ser_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = PKT_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = PKT_LOAD;
                    end
                end
            end
            PKT_DONE: begin
                w_state_nxt = PKT_IDLE;
            end
            default: begin
                w_state_nxt = PKT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= PKT_IDLE;
            r_idx           <= 2'd0;
            r_word          <= '0;
            r_count_packets <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_accept) begin
                r_word <= pkt_pack(pkt_addr, pkt_data, pkt_footer);
            end
            if (r_state == PKT_DONE) begin
                r_count_packets <= r_count_packets + CNT_W'(1);
            end
        end
    end

    uart_tx_byte #(
        .FREQ (FREQ),
        .BAUD (BAUD)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .din   (w_byte),
        .txd   (w_ser_txd),
        .done  (w_ser_done),
        .busy  (w_ser_busy)
    );

    assign pkt_ready     = (r_state == PKT_IDLE);
    assign tx_en         = w_start;
    assign tx_byte       = w_start ? w_byte : 8'h00;
    assign busy          = (r_state != PKT_IDLE) || w_ser_busy;
    assign count_packets = r_count_packets;
    assign txd           = w_ser_txd;

endmodule

// File: tb/tb_pkt_uart_tx.sv
// Directed bench for pkt_uart_tx: tx_en byte capture plus an independent txd decoder
// at 160 clocks per bit, checked against hand-computed frames.
module tb_pkt_uart_tx;

    localparam int CPB     = 160;
    localparam int HALF    = 80;
    localparam int PKT_GAP = 3 * (10 * CPB + 1) + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [9:0]  pkt_addr = 10'h000;
    logic [7:0]  pkt_data = 8'h00;
    logic [2:0]  pkt_footer = 3'b000;
    logic        txd;
    logic        tx_en;
    logic [7:0]  tx_byte;
    logic        busy;
    logic [15:0] count_packets;

    pkt_uart_tx #(
        .FREQ  (100_000_000),
        .BAUD  (625_000),
        .CNT_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_addr      (pkt_addr),
        .pkt_data      (pkt_data),
        .pkt_footer    (pkt_footer),
        .txd           (txd),
        .tx_en         (tx_en),
        .tx_byte       (tx_byte),
        .busy          (busy),
        .count_packets (count_packets)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int drv_timeouts = 0;
    int acc_cyc = 0;
    int frame_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] en_q[$];
    logic [7:0] dec_q[$];
    int         en_t[$];
    int         start_t[$];

    // tx_en strobe capture
    always @(negedge clk) begin
        if (!rst && tx_en === 1'b1) begin
            en_q.push_back(tx_byte);
            en_t.push_back(cyc);
        end
    end

    // txd decoder, sampling mid-bit
    logic       prev_txd = 1'b1;
    bit         dec_on = 1'b0;
    int         dec_cnt = 0;
    int         dec_k = 0;
    logic [7:0] dec_sh = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (prev_txd === 1'b1 && txd === 1'b0) begin
                dec_on  = 1'b1;
                dec_cnt = 0;
                start_t.push_back(cyc);
            end
        end else begin
            dec_cnt++;
            if (dec_cnt >= HALF && ((dec_cnt - HALF) % CPB) == 0) begin
                dec_k = (dec_cnt - HALF) / CPB;
                if (dec_k == 0) begin
                    if (txd !== 1'b0) frame_err++;
                end else if (dec_k <= 8) begin
                    dec_sh[dec_k-1] = txd;
                end else begin
                    if (txd !== 1'b1) frame_err++;
                    dec_q.push_back(dec_sh);
                    dec_on = 1'b0;
                end
            end
        end
        prev_txd = txd;
    end

    // ---------------- model and drivers ----------------
    function automatic logic [23:0] model_word(input logic [9:0] a, input logic [7:0] d,
                                               input logic [2:0] f);
        return {3'b101, a, d, f};
    endfunction

    task automatic push_exp(input logic [9:0] a, input logic [7:0] d, input logic [2:0] f);
        logic [23:0] w;
        w = model_word(a, d, f);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic clear_mon();
        en_q.delete();
        en_t.delete();
        dec_q.delete();
        start_t.delete();
        exp_q.delete();
        frame_err = 0;
        drv_timeouts = 0;
    endtask

    task automatic send_pkt(input logic [9:0] a, input logic [7:0] d, input logic [2:0] f);
        int n;
        @(negedge clk);
        pkt_valid  = 1'b1;
        pkt_addr   = a;
        pkt_data   = d;
        pkt_footer = f;
        n = 0;
        while (pkt_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            drv_timeouts++;
            pkt_valid = 1'b0;
            return;
        end
        @(negedge clk);
        acc_cyc    = cyc;
        pkt_valid  = 1'b0;
        pkt_addr   = 10'($urandom);
        pkt_data   = 8'($urandom);
        pkt_footer = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || pkt_ready !== 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) drv_timeouts++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        pkt_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        total++;
        if (tx_byte !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs tx_byte=%h busy=%b exp 00/0", tx_byte, busy);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if (txd !== 1'b1 || pkt_ready !== 1'b1 || tx_en !== 1'b0 || count_packets !== 16'h0000) begin
                bad++;
                $display("FAIL reset_idle cyc%0d txd=%b ready=%b tx_en=%b count=%h exp 1/1/0/0000",
                         i, txd, pkt_ready, tx_en, count_packets);
            end
        end
    endtask

    task automatic test_single();
        clear_mon();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h02);
        send_pkt(10'h001, 8'h00, 3'b010);
        wait_idle();
        total++;
        if (en_q.size() != 3 || dec_q.size() != 3) begin
            bad++;
            $display("FAIL single_nbytes en=%0d dec=%0d exp 3", en_q.size(), dec_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= en_q.size() || en_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_en_byte%0d got=%h exp=%h", i, (i < en_q.size()) ? en_q[i] : 8'hxx, exp_q[i]);
            end
            total++;
            if (i >= dec_q.size() || dec_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_txd_byte%0d got=%h exp=%h", i, (i < dec_q.size()) ? dec_q[i] : 8'hxx, exp_q[i]);
            end
        end
        total++;
        if (en_t.size() < 1 || en_t[0] != acc_cyc) begin
            bad++;
            $display("FAIL single_tx_en_latency got=%0d exp=%0d", (en_t.size() > 0) ? en_t[0] : -1, acc_cyc);
        end
        total++;
        if (start_t.size() < 1 || start_t[0] != acc_cyc + 1) begin
            bad++;
            $display("FAIL single_start_latency got=%0d exp=%0d", (start_t.size() > 0) ? start_t[0] : -1, acc_cyc + 1);
        end
        total++;
        if (count_packets !== 16'h0001 || frame_err != 0 || drv_timeouts != 0) begin
            bad++;
            $display("FAIL single_count got=%h ferr=%0d tmo=%0d exp 0001/0/0", count_packets, frame_err, drv_timeouts);
        end
    endtask

    task automatic test_pattern();
        clear_mon();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'h28);
        send_pkt(10'h155, 8'hA5, 3'b000);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= en_q.size() || en_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL pattern_en_byte%0d got=%h exp=%h", i, (i < en_q.size()) ? en_q[i] : 8'hxx, exp_q[i]);
            end
            total++;
            if (i >= dec_q.size() || dec_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL pattern_txd_byte%0d got=%h exp=%h", i, (i < dec_q.size()) ? dec_q[i] : 8'hxx, exp_q[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (i >= start_t.size() || start_t[i] - start_t[i-1] != 10 * CPB + 1) begin
                bad++;
                $display("FAIL pattern_start_spacing%0d got=%0d exp=%0d", i,
                         (i < start_t.size()) ? start_t[i] - start_t[i-1] : -1, 10 * CPB + 1);
            end
        end
        total++;
        if (count_packets !== 16'h0002 || frame_err != 0 || drv_timeouts != 0) begin
            bad++;
            $display("FAIL pattern_count got=%h ferr=%0d tmo=%0d exp 0002/0/0", count_packets, frame_err, drv_timeouts);
        end
    endtask

    task automatic test_back_to_back();
        int acc_t[10];
        int n_acc;
        int guard;
        clear_mon();
        exp_q.push_back(8'hBF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        send_pkt(10'h3FF, 8'hFF, 3'b111);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= dec_q.size() || dec_q[i] !== exp_q[i] || i >= en_q.size() || en_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_ones_byte%0d en=%h txd=%h exp=%h", i,
                         (i < en_q.size()) ? en_q[i] : 8'hxx, (i < dec_q.size()) ? dec_q[i] : 8'hxx, exp_q[i]);
            end
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        for (int p = 0; p < 10; p++) push_exp(10'(p), 8'hFF, 3'b111);
        pkt_valid  = 1'b1;
        pkt_addr   = 10'h000;
        pkt_data   = 8'hFF;
        pkt_footer = 3'b111;
        n_acc = 0;
        guard = 0;
        while (n_acc < 10 && guard < 60000) begin
            if (pkt_ready === 1'b1) begin
                @(negedge clk);
                guard++;
                acc_t[n_acc] = cyc;
                n_acc++;
                total++;
                if (pkt_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_ready_pulse pkt%0d got=%b exp=0", n_acc - 1, pkt_ready);
                end
                if (n_acc < 10) pkt_addr = 10'(n_acc);
                else pkt_valid = 1'b0;
            end else begin
                @(negedge clk);
                guard++;
            end
        end
        pkt_valid = 1'b0;
        total++;
        if (n_acc != 10) begin
            bad++;
            $display("FAIL b2b_accepts got=%0d exp=10", n_acc);
        end
        for (int i = 1; i < n_acc; i++) begin
            total++;
            if (acc_t[i] - acc_t[i-1] != PKT_GAP) begin
                bad++;
                $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, acc_t[i] - acc_t[i-1], PKT_GAP);
            end
        end
        wait_idle();
        total++;
        if (en_q.size() != 30 || dec_q.size() != 30) begin
            bad++;
            $display("FAIL b2b_nbytes en=%0d dec=%0d exp 30", en_q.size(), dec_q.size());
        end
        for (int i = 0; i < 30; i++) begin
            total++;
            if (i >= en_q.size() || en_q[i] !== exp_q[i] || i >= dec_q.size() || dec_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_byte%0d en=%h txd=%h exp=%h", i,
                         (i < en_q.size()) ? en_q[i] : 8'hxx, (i < dec_q.size()) ? dec_q[i] : 8'hxx, exp_q[i]);
            end
        end
        total++;
        if (count_packets !== 16'h000A || frame_err != 0 || drv_timeouts != 0) begin
            bad++;
            $display("FAIL b2b_count got=%h ferr=%0d tmo=%0d exp 000A/0/0", count_packets, frame_err, drv_timeouts);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        clear_mon();
        send_pkt(10'h000, 8'h00, 3'b000);
        n = 0;
        while (start_t.size() < 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (start_t.size() < 2) begin
            bad++;
            $display("FAIL midrst_byte1_start got=%0d starts exp=2", start_t.size());
        end
        repeat (800) @(negedge clk);
        total++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_before txd=%b busy=%b exp 0/1", txd, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (txd !== 1'b1 || count_packets !== 16'h0000 || busy !== 1'b0 || pkt_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_after txd=%b count=%h busy=%b ready=%b exp 1/0000/0/1",
                     txd, count_packets, busy, pkt_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        push_exp(10'h2C3, 8'h5A, 3'b101);
        send_pkt(10'h2C3, 8'h5A, 3'b101);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= en_q.size() || en_q[i] !== exp_q[i] || i >= dec_q.size() || dec_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midrst_new_byte%0d en=%h txd=%h exp=%h", i,
                         (i < en_q.size()) ? en_q[i] : 8'hxx, (i < dec_q.size()) ? dec_q[i] : 8'hxx, exp_q[i]);
            end
        end
        total++;
        if (count_packets !== 16'h0001 || frame_err != 0 || drv_timeouts != 0 || dec_q.size() != 3) begin
            bad++;
            $display("FAIL midrst_new_count got=%h ferr=%0d tmo=%0d nbytes=%0d exp 0001/0/0/3",
                     count_packets, frame_err, drv_timeouts, dec_q.size());
        end
    endtask

    task automatic test_count_wrap();
        clear_mon();
        @(negedge clk);
        force dut.r_count_packets = 16'hFFFF;
        @(negedge clk);
        release dut.r_count_packets;
        @(negedge clk);
        total++;
        if (count_packets !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_preset got=%h exp=FFFF", count_packets);
        end
        send_pkt(10'h0F0, 8'h81, 3'b011);
        wait_idle();
        total++;
        if (count_packets !== 16'h0000 || drv_timeouts != 0) begin
            bad++;
            $display("FAIL wrap_count got=%h tmo=%0d exp 0000/0", count_packets, drv_timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pattern();
        test_back_to_back();
        test_mid_reset();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
